// File: rtl/filter_rate_ctrl.sv
// Symbol-rate scheduler between the QAM mapper and filter_top: zero-stuffs
// mapper symbols at the selected baud and drains the RRC filters before any rate change.
module filter_rate_ctrl #(
  parameter int unsigned DRAIN_SYMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic [1:0]  rate_req,
  input  logic        rate_req_valid,
  output logic        rate_req_ready,
  input  logic [31:0] sym_i,
  input  logic [31:0] sym_q,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [31:0] filter_in_i,
  output logic [31:0] filter_in_q,
  output logic [1:0]  baud_rate,
  output logic        filter_enable,
  output logic        busy,
  output logic        underrun
);

  localparam int CNT_W = (DRAIN_SYMS < 2) ? 1 : $clog2(DRAIN_SYMS + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_SYMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SWITCH
  } state_t;

  state_t           state, state_next;
  logic [4:0]       phase;
  logic [1:0]       pending, pending_next;
  logic [CNT_W-1:0] drain_cnt;

  logic [4:0] period_mask;
  logic [4:0] hold_len;
  logic [4:0] phase_mod;
  logic       slot;
  logic       hold_end;
  logic       req_fire;

  // Period and hold window are powers of two, so phase % P is a mask.
  always_comb begin
    period_mask = 5'd31;
    hold_len    = 5'd8;
    unique case (baud_rate)
      2'b00: begin period_mask = 5'd31; hold_len = 5'd8; end
      2'b01: begin period_mask = 5'd15; hold_len = 5'd4; end
      2'b10: begin period_mask = 5'd7;  hold_len = 5'd2; end
      2'b11: begin period_mask = 5'd3;  hold_len = 5'd1; end
      default: begin period_mask = 5'd31; hold_len = 5'd8; end
    endcase
  end

  assign phase_mod = phase & period_mask;
  assign slot      = (phase_mod == 5'd0);
  assign hold_end  = (phase_mod == hold_len);

  assign rate_req_ready = (state == S_IDLE) || (state == S_RUN);
  assign req_fire       = rate_req_valid & rate_req_ready;
  assign sym_ready      = (state == S_RUN) && slot;
  assign filter_enable  = (state != S_IDLE);
  assign busy           = (state == S_DRAIN) || (state == S_SWITCH);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    unique case (state)
      S_IDLE: begin
        if (run_en) state_next = S_RUN;
      end
      S_RUN: begin
        if (req_fire && (rate_req != baud_rate)) begin
          pending_next = rate_req;
          state_next   = S_DRAIN;
        end else if (!run_en) begin
          pending_next = baud_rate;
          state_next   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (slot && (drain_cnt == DRAIN_LAST)) state_next = S_SWITCH;
      end
      S_SWITCH: begin
        state_next = run_en ? S_RUN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, all reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pending <= 2'b00;
      phase   <= 5'd0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      phase   <= phase + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_rate <= 2'b00;
    end else if ((state == S_IDLE) && req_fire) begin
      baud_rate <= rate_req;
    end else if (state == S_SWITCH) begin
      baud_rate <= pending;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state != S_DRAIN) begin
      drain_cnt <= '0;
    end else if (slot) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Sample is loaded at a slot, held for one filter sample period, then zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_in_i <= '0;
      filter_in_q <= '0;
    end else if (state == S_SWITCH) begin
      filter_in_i <= '0;
      filter_in_q <= '0;
    end else if ((state == S_RUN) && slot) begin
      filter_in_i <= sym_valid ? sym_i : '0;
      filter_in_q <= sym_valid ? sym_q : '0;
    end else if (slot || hold_end) begin
      filter_in_i <= '0;
      filter_in_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= (state == S_RUN) && slot && !sym_valid;
    end
  end

endmodule

// File: tb/tb_filter_rate_ctrl.sv
// Directed bench for filter_rate_ctrl: table of per-rate run vectors plus
// hand-written sequences for rate switch, same-rate request, stop and reset mid-drain.
module tb_filter_rate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic [1:0]  rate_req;
  logic        rate_req_valid;
  logic        rate_req_ready;
  logic [31:0] sym_i, sym_q;
  logic        sym_valid;
  logic        sym_ready;
  logic [31:0] filter_in_i, filter_in_q;
  logic [1:0]  baud_rate;
  logic        filter_enable;
  logic        busy;
  logic        underrun;

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;

  filter_rate_ctrl #(.DRAIN_SYMS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_en         (run_en),
    .rate_req       (rate_req),
    .rate_req_valid (rate_req_valid),
    .rate_req_ready (rate_req_ready),
    .sym_i          (sym_i),
    .sym_q          (sym_q),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .filter_in_i    (filter_in_i),
    .filter_in_q    (filter_in_q),
    .baud_rate      (baud_rate),
    .filter_enable  (filter_enable),
    .busy           (busy),
    .underrun       (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    int          per;
    int          hold;
    logic        valid;
    logic [31:0] si;
    logic [31:0] sq;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    run_en         = 1'b0;
    rate_req       = 2'b00;
    rate_req_valid = 1'b0;
    sym_valid      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fi_i", filter_in_i, 32'd0);
    check("rst_fi_q", filter_in_q, 32'd0);
    check("rst_sym_ready", {31'd0, sym_ready}, 32'd0);
    check("rst_enable", {31'd0, filter_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_baud", {30'd0, baud_rate}, 32'd0);
    rst_n = 1'b1;
    t = 0;
    check("rst_req_ready", {31'd0, rate_req_ready}, 32'd1);
  endtask

  task automatic start_run(input logic [1:0] code);
    rate_req       = code;
    rate_req_valid = 1'b1;
    run_en         = 1'b1;
    tick();
    rate_req_valid = 1'b0;
    check("start_baud", {30'd0, baud_rate}, {30'd0, code});
    check("start_enable", {31'd0, filter_enable}, 32'd1);
  endtask

  task automatic tick_to(input int target);
    while (t < target) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d got timeout want finish", t);
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] exp_s_i, exp_s_q;
    logic        seen, is_slot;
    int          off;

    rst_n = 1'b0; run_en = 1'b0; rate_req = 2'b00; rate_req_valid = 1'b0;
    sym_i = '0; sym_q = '0; sym_valid = 1'b0;

    vecs[0] = '{2'b11, 4,  1, 1'b1, 32'h0001_0000, 32'hFFFF_0000};
    vecs[1] = '{2'b00, 32, 8, 1'b1, 32'h7FFF_0000, 32'h8001_0000};
    vecs[2] = '{2'b10, 8,  2, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[3] = '{2'b01, 16, 4, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001};

    // Steady-state RUN at each rate, starting from IDLE at phase 0.
    for (int n = 0; n < 4; n++) begin
      v = vecs[n];
      do_reset();
      sym_valid = v.valid;
      sym_i     = v.si;
      sym_q     = v.sq;
      start_run(v.code);
      seen = 1'b0;
      off  = 0;
      for (int k = 0; k < 2 * v.per + 2; k++) begin
        is_slot = ((t % v.per) == 0);
        exp_s_i = (seen && off >= 1 && off <= v.hold && v.valid) ? v.si : 32'd0;
        exp_s_q = (seen && off >= 1 && off <= v.hold && v.valid) ? v.sq : 32'd0;
        check("run_sym_ready", {31'd0, sym_ready}, {31'd0, is_slot});
        check("run_fi_i", filter_in_i, exp_s_i);
        check("run_fi_q", filter_in_q, exp_s_q);
        check("run_underrun", {31'd0, underrun},
              {31'd0, (seen && off == 1 && !v.valid)});
        check("run_busy", {31'd0, busy}, 32'd0);
        if (is_slot) begin
          seen = 1'b1;
          off  = 0;
        end
        tick();
        off++;
      end
    end

    // Rate switch 01 -> 11: request at t=17, drain slots 32..144, SWITCH at 145.
    do_reset();
    sym_valid = 1'b1; sym_i = 32'h0BAD_F00D; sym_q = 32'h0000_0005;
    start_run(2'b01);
    tick_to(17);
    check("sw_pre_fi_i", filter_in_i, 32'h0BAD_F00D);
    check("sw_pre_ready", {31'd0, rate_req_ready}, 32'd1);
    rate_req = 2'b11; rate_req_valid = 1'b1;
    tick();
    rate_req_valid = 1'b0;
    while (t <= 145) begin
      check("sw_busy", {31'd0, busy}, 32'd1);
      check("sw_sym_ready", {31'd0, sym_ready}, 32'd0);
      check("sw_req_ready", {31'd0, rate_req_ready}, 32'd0);
      check("sw_baud_old", {30'd0, baud_rate}, 32'd1);
      check("sw_fi_i", filter_in_i, (t <= 20) ? 32'h0BAD_F00D : 32'd0);
      tick();
    end
    check("sw_busy_fall", {31'd0, busy}, 32'd0);
    check("sw_baud_new", {30'd0, baud_rate}, 32'd3);
    check("sw_no_slot_146", {31'd0, sym_ready}, 32'd0);
    tick();
    check("sw_no_slot_147", {31'd0, sym_ready}, 32'd0);
    tick();
    check("sw_slot_148", {31'd0, sym_ready}, 32'd1);
    tick();
    check("sw_fi_149", filter_in_i, 32'h0BAD_F00D);
    tick_to(152);
    check("sw_slot_152", {31'd0, sym_ready}, 32'd1);

    // Request equal to the current rate is accepted without a drain.
    do_reset();
    sym_valid = 1'b1; sym_i = 32'h0000_00AA; sym_q = 32'h0000_00BB;
    start_run(2'b01);
    tick_to(17);
    rate_req = 2'b01; rate_req_valid = 1'b1;
    check("same_ready", {31'd0, rate_req_ready}, 32'd1);
    tick();
    rate_req_valid = 1'b0;
    check("same_busy", {31'd0, busy}, 32'd0);
    tick_to(32);
    check("same_slot_32", {31'd0, sym_ready}, 32'd1);
    check("same_baud", {30'd0, baud_rate}, 32'd1);

    // Request 10 together with run_en fall at code 11: drain 8..36, SWITCH 37, IDLE at 38.
    do_reset();
    sym_valid = 1'b1; sym_i = 32'h0000_1111; sym_q = 32'h0000_2222;
    start_run(2'b11);
    tick_to(5);
    rate_req = 2'b10; rate_req_valid = 1'b1; run_en = 1'b0;
    tick();
    rate_req_valid = 1'b0;
    check("stop_busy_6", {31'd0, busy}, 32'd1);
    tick_to(37);
    check("stop_busy_37", {31'd0, busy}, 32'd1);
    tick();
    check("stop_busy_38", {31'd0, busy}, 32'd0);
    check("stop_baud", {30'd0, baud_rate}, 32'd2);
    check("stop_enable", {31'd0, filter_enable}, 32'd0);
    check("stop_req_ready", {31'd0, rate_req_ready}, 32'd1);
    tick_to(40);
    check("stop_idle_slot", {31'd0, sym_ready}, 32'd0);
    check("stop_fi_i", filter_in_i, 32'd0);

    // Reset during DRAIN discards the pending rate.
    do_reset();
    sym_valid = 1'b1; sym_i = 32'h0000_3333; sym_q = 32'h0000_4444;
    start_run(2'b01);
    tick_to(17);
    rate_req = 2'b10; rate_req_valid = 1'b1;
    tick();
    rate_req_valid = 1'b0;
    tick_to(40);
    check("mid_busy", {31'd0, busy}, 32'd1);
    run_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_baud", {30'd0, baud_rate}, 32'd0);
    check("mid_rst_enable", {31'd0, filter_enable}, 32'd0);
    check("mid_rst_fi_i", filter_in_i, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    tick_to(200);
    check("mid_after_baud", {30'd0, baud_rate}, 32'd0);
    check("mid_after_busy", {31'd0, busy}, 32'd0);
    check("mid_after_enable", {31'd0, filter_enable}, 32'd0);
    check("mid_after_fi_q", filter_in_q, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filter_rate_ctrl.md
# filter_rate_ctrl

Symbol-rate scheduler that sits between the QAM mapper and `filter_top`. It turns mapper symbols into zero-stuffed I/Q sample streams at the 76800 Hz system clock. It drives `baud_rate` and `enable` on `filter_top`. It changes the symbol rate only after draining the active root-raised-cosine filters with zeros, so a rate switch never mixes old-rate symbols into the new-rate filter.

## Interface
- `DRAIN_SYMS`, default 8: number of zero-symbol periods emitted before a rate switch or stop (covers filter span).
- `clk` in 1: 76800 Hz system clock, shared with `filter_top`.
- `rst_n` in 1: asynchronous, active-low reset. Must be the same reset that drives `filter_top`.
- `run_en` in 1: level; 1 = transmit symbols, 0 = drain and stop.
- `rate_req` in 2: requested baud code. 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200.
- `rate_req_valid` in 1: request qualifier.
- `rate_req_ready` out 1: request accepted when `rate_req_valid & rate_req_ready`.
- `sym_i`, `sym_q` in 32 each: mapper symbol, signed.
- `sym_valid` in 1: mapper has a symbol.
- `sym_ready` out 1: symbol consumed when `sym_valid & sym_ready`.
- `filter_in_i`, `filter_in_q` out 32 each: zero-stuffed samples to `filter_top`.
- `baud_rate` out 2: to `filter_top.baud_rate`.
- `filter_enable` out 1: to `filter_top.enable`.
- `busy` out 1: high in DRAIN or SWITCH.
- `underrun` out 1: one-cycle pulse on a symbol slot with no symbol available.

## Operation
- Phase counter: 5-bit free-running counter, reset to 0, increments every clk. Its low 3 bits track the `filter_top` divider exactly.
- Symbol period P = 32, 16, 8, 4 clk for codes 00, 01, 10, 11. Hold window H = P/4 = 8, 4, 2, 1 clk, which is one filter sample period (4 samples per symbol).
- Slot: a cycle with `phase % P == 0`.
- States:
  - IDLE: outputs zero, `sym_ready=0`, `filter_enable=0`, `rate_req_ready=1`. An accepted request loads `baud_rate` on the next edge. `run_en=1` moves to RUN.
  - RUN: `filter_enable=1`, `rate_req_ready=1`. `sym_ready=1` combinationally in slot cycles only.
    - Slot with `sym_valid`: register `sym_i`/`sym_q`.
    - Slot without `sym_valid`: register zero and pulse `underrun`.
    - Accepted request with `rate_req != baud_rate`: latch `rate_req` into pending, go to DRAIN.
    - Accepted request equal to `baud_rate`: accepted, no state change.
    - `run_en=0`: go to DRAIN with pending = current `baud_rate`.
  - DRAIN: `sym_ready=0`, `rate_req_ready=0`, `filter_enable=1`, outputs zero after the current hold window ends. Count slots. On the DRAIN_SYMS-th slot, go to SWITCH.
  - SWITCH: one cycle. `baud_rate <= pending`, zero-stuff registers cleared. Next state is RUN if `run_en`, else IDLE.
- Zero-stuffing: the registered sample is driven for H cycles after the slot edge, then `filter_in_*` = 0 until the next slot.
- A simultaneous request and `run_en` fall in RUN: latch the request, drain, switch, then go to IDLE at the new rate.
- No datapath arithmetic. Samples pass through unmodified and full width.

## Timing
- Reset values:
  - state IDLE, phase 0, `baud_rate`=00, pending 00.
  - `filter_in_i`/`filter_in_q`=0, `sym_ready`=0, `filter_enable`=0, `busy`=0, `underrun`=0.
  - `rate_req_ready`=1 once `rst_n` deasserts.
- Symbol handshake at slot cycle S: sample appears on `filter_in_*` at S+1 and stays through S+H. Zero from S+H+1 to the next slot. The window contains exactly one rising edge of the selected filter sample clock.
- `underrun` is asserted in cycle S, registered, visible at S+1 for one cycle.
- Rate request accepted in cycle R: DRAIN from R+1, `busy`=1 from R+1.
- Drain length: zero slots counted at the old P. SWITCH follows the DRAIN_SYMS-th slot by one cycle. `baud_rate` is updated one cycle after SWITCH, `busy` falls at the same time.
- First new-rate slot: the first `phase % P_new == 0` after SWITCH.
- Reset mid-DRAIN: immediate return to reset values. The pending rate is discarded.
- `run_en` rising in IDLE: RUN next cycle. The first consumption happens at the next slot, never mid-period.

## Test plan
- Reset, `run_en=1`, code 11, `sym_valid=1`, `sym_i`=0x00010000: `sym_ready` pulses at phase 0, 4, 8, …. `filter_in_i`=0x00010000 for 1 cycle, then 0 for 3 cycles.
- Code 00 with a constant symbol 0x7FFF0000: consumption every 32 clk. The sample is held 8 clk at phase 1..8, zero for phase 9..31.
- `sym_valid=0` at a code-10 slot: `underrun` pulses one cycle, `filter_in_*`=0 for the whole period, no handshake.
- In RUN at code 01, request 11: `busy` high, no `sym_ready` for 8 slots × 16 clk. `baud_rate` becomes 11 one cycle after SWITCH. Consumption resumes every 4 clk.
- Request 01 while at 01: accepted, `busy` stays 0, slot cadence unchanged.
- Reset asserted mid-DRAIN, then released: `baud_rate`=00, state IDLE, outputs 0, no switch to the pending code.
